// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch controller: owns the fetch PC, buffers fetched words in a
// 2-entry prefetch queue, applies redirects with a flush and flags illegal PCs.
module instr_fetch_ctrl #(
  parameter int unsigned                DATA_WIDTH   = 32,
  parameter int unsigned                MEMORY_DEPTH = 32,
  parameter logic [DATA_WIDTH-1:0]      RESET_PC     = DATA_WIDTH'(32'h0040_0000)
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic [DATA_WIDTH-1:0] Mem_Address_o,
  input  logic [DATA_WIDTH-1:0] Mem_Instruction_i,
  input  logic                  Stall_i,
  input  logic                  Redirect_i,
  input  logic [DATA_WIDTH-1:0] Redirect_PC_i,
  output logic                  Instr_Valid_o,
  output logic [DATA_WIDTH-1:0] Instr_o,
  output logic [DATA_WIDTH-1:0] Instr_PC_o,
  output logic                  Fault_o
);

  logic [DATA_WIDTH-1:0]        fetch_pc;
  logic [1:0][DATA_WIDTH-1:0]   q_pc;
  logic [1:0][DATA_WIDTH-1:0]   q_instr;
  logic                         head;
  logic [1:0]                   count;

  logic [31:0]                  word_idx;
  logic                         legal;
  logic                         pop;
  logic                         push;
  logic                         tail;

  always_comb begin
    word_idx = {17'b0, fetch_pc[16:2]};
    legal    = (fetch_pc[1:0] == 2'b00) && (word_idx < MEMORY_DEPTH);
    pop      = (count != 2'd0) && !Stall_i;
    push     = !Redirect_i && legal && ((count != 2'd2) || pop);
    // With count==2 and a pop, the free slot is the one being vacated (head).
    tail     = head ^ count[0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc <= RESET_PC;
      q_pc     <= {2{RESET_PC}};
      q_instr  <= '0;
      head     <= 1'b0;
      count    <= '0;
    end else if (Redirect_i) begin
      fetch_pc <= Redirect_PC_i;
      head     <= 1'b0;
      count    <= '0;
    end else begin
      if (push) begin
        q_pc[tail]    <= fetch_pc;
        q_instr[tail] <= Mem_Instruction_i;
        fetch_pc      <= fetch_pc + DATA_WIDTH'(4);
      end
      if (pop) begin
        head <= ~head;
      end
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  assign Mem_Address_o = fetch_pc;
  assign Instr_Valid_o = (count != 2'd0);
  assign Instr_o       = q_instr[head];
  assign Instr_PC_o    = q_pc[head];
  assign Fault_o       = !legal && (count == 2'd0);

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Bench for instr_fetch_ctrl: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_instr_fetch_ctrl;

  localparam logic [31:0] RST_PC = 32'h0040_0000;
  localparam int unsigned DEPTH  = 32;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
  } ent_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] Mem_Address_o;
  logic [31:0] Mem_Instruction_i;
  logic        Stall_i = 1'b0;
  logic        Redirect_i = 1'b0;
  logic [31:0] Redirect_PC_i = '0;
  logic        Instr_Valid_o;
  logic [31:0] Instr_o;
  logic [31:0] Instr_PC_o;
  logic        Fault_o;

  int n_checks = 0;
  int n_err    = 0;
  bit cmp_en   = 1'b0;

  ent_t        mq[$];
  logic [31:0] m_pc = RST_PC;

  always #5 clk = ~clk;

  function automatic logic [31:0] memword(input logic [31:0] a);
    return 32'h1000 + {17'b0, a[16:2]};
  endfunction

  function automatic bit legal_pc(input logic [31:0] a);
    return (a[1:0] == 2'b00) && ({17'b0, a[16:2]} < DEPTH);
  endfunction

  assign Mem_Instruction_i = memword(Mem_Address_o);

  instr_fetch_ctrl #(
    .DATA_WIDTH(32),
    .MEMORY_DEPTH(DEPTH),
    .RESET_PC(RST_PC)
  ) dut (
    .clk(clk),
    .reset(reset),
    .Mem_Address_o(Mem_Address_o),
    .Mem_Instruction_i(Mem_Instruction_i),
    .Stall_i(Stall_i),
    .Redirect_i(Redirect_i),
    .Redirect_PC_i(Redirect_PC_i),
    .Instr_Valid_o(Instr_Valid_o),
    .Instr_o(Instr_o),
    .Instr_PC_o(Instr_PC_o),
    .Fault_o(Fault_o)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain FIFO of {pc, instr} plus the fetch PC.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mq.delete();
      m_pc = RST_PC;
    end else if (Redirect_i) begin
      mq.delete();
      m_pc = Redirect_PC_i;
    end else begin
      bit ok;
      ok = legal_pc(m_pc);
      if (mq.size() != 0 && !Stall_i) void'(mq.pop_front());
      if (ok && mq.size() < 2) begin
        mq.push_back('{pc: m_pc, ins: memword(m_pc)});
        m_pc = m_pc + 32'd4;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("valid", {31'b0, Instr_Valid_o}, {31'b0, mq.size() != 0});
      chk("mem_addr", Mem_Address_o, m_pc);
      chk("fault", {31'b0, Fault_o}, {31'b0, !legal_pc(m_pc) && mq.size() == 0});
      if (mq.size() != 0) begin
        chk("instr", Instr_o, mq[0].ins);
        chk("instr_pc", Instr_PC_o, mq[0].pc);
      end
      if (!reset) begin
        chk("rst_instr", Instr_o, 32'h0);
        chk("rst_instr_pc", Instr_PC_o, RST_PC);
      end
    end
  end

  task automatic step(input bit st, input bit rd, input logic [31:0] rpc);
    Stall_i       = st;
    Redirect_i    = rd;
    Redirect_PC_i = rpc;
    @(posedge clk);
    #1;
  endtask

  task automatic head_is(input string name, input logic [31:0] ins, input logic [31:0] pc);
    chk({name, "_v"}, {31'b0, Instr_Valid_o}, 32'd1);
    chk({name, "_i"}, Instr_o, ins);
    chk({name, "_pc"}, Instr_PC_o, pc);
  endtask

  initial begin
    reset = 1'b1;
    #1 reset = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    cmp_en = 1'b1;
    chk("reset_valid", {31'b0, Instr_Valid_o}, 32'd0);
    chk("reset_addr", Mem_Address_o, 32'h0040_0000);
    chk("reset_pc_o", Instr_PC_o, 32'h0040_0000);
    chk("reset_instr", Instr_o, 32'h0);
    chk("reset_fault", {31'b0, Fault_o}, 32'd0);
    reset = 1'b1;

    // Streaming, one per cycle
    step(0, 0, 0);
    head_is("first", 32'h1000, 32'h0040_0000);
    chk("addr1", Mem_Address_o, 32'h0040_0004);
    step(0, 0, 0);
    head_is("second", 32'h1001, 32'h0040_0004);
    step(0, 0, 0);
    head_is("third", 32'h1002, 32'h0040_0008);

    // Stall: queue fills, fetch PC holds
    for (int i = 0; i < 4; i++) step(1, 0, 0);
    chk("stall_addr", Mem_Address_o, 32'h0040_0010);
    head_is("stall_head", 32'h1002, 32'h0040_0008);
    step(0, 0, 0);
    head_is("resume1", 32'h1003, 32'h0040_000C);
    step(0, 0, 0);
    head_is("resume2", 32'h1004, 32'h0040_0010);

    // Redirect while full and stalled
    step(1, 0, 0);
    step(1, 0, 0);
    step(1, 1, 32'h0040_0040);
    chk("redir_valid", {31'b0, Instr_Valid_o}, 32'd0);
    step(1, 0, 0);
    head_is("redir_head", 32'h1010, 32'h0040_0040);

    // Run off the end of memory
    step(0, 1, 32'h0040_0070);
    for (int i = 0; i < 8; i++) step(0, 0, 0);
    chk("end_fault", {31'b0, Fault_o}, 32'd1);
    chk("end_addr", Mem_Address_o, 32'h0040_0080);
    chk("end_valid", {31'b0, Instr_Valid_o}, 32'd0);
    step(0, 1, 32'h0040_0000);
    chk("clr_fault", {31'b0, Fault_o}, 32'd0);
    step(0, 0, 0);
    head_is("restart", 32'h1000, 32'h0040_0000);

    // Misaligned redirect
    step(0, 1, 32'h0040_0002);
    chk("mis_fault", {31'b0, Fault_o}, 32'd1);
    chk("mis_valid", {31'b0, Instr_Valid_o}, 32'd0);
    step(0, 0, 0);
    step(0, 0, 0);
    chk("mis_valid2", {31'b0, Instr_Valid_o}, 32'd0);
    chk("mis_fault2", {31'b0, Fault_o}, 32'd1);

    // Async reset mid-stall with a full queue
    step(0, 1, 32'h0040_0000);
    step(1, 0, 0);
    step(1, 0, 0);
    step(1, 0, 0);
    reset = 1'b0;
    #1;
    chk("async_valid", {31'b0, Instr_Valid_o}, 32'd0);
    chk("async_addr", Mem_Address_o, 32'h0040_0000);
    chk("async_pc_o", Instr_PC_o, 32'h0040_0000);
    chk("async_instr", Instr_o, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    step(0, 0, 0);
    head_is("post_rst", 32'h1000, 32'h0040_0000);

    // Randomized traffic
    for (int n = 0; n < 2000; n++) begin
      logic [31:0] rpc;
      if ($urandom_range(0, 299) == 0) begin
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
      end else begin
        rpc = RST_PC + (32'($urandom_range(0, 39)) << 2);
        if ($urandom_range(0, 7) == 0) rpc = rpc + 32'($urandom_range(1, 3));
        step($urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0, rpc);
      end
    end

    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
